// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin select generator for a 4:1 mux. It produces a registered sel code,
// a one-hot grant and a valid flag, and bounds how long one owner may hold the mux.
module mux_sel_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  // state | meaning
  // IDLE  | no owner; gnt=0, sel holds the last owner
  // OWN   | owner is sel; gnt=onehot(sel), hold_cnt counts owned cycles
  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_d;
  logic [3:0]       gnt_d;
  logic             valid_d;
  logic [CNT_W-1:0] hold_d;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic             release_own;
  logic             preempt_own;

  // Returns {found, index} of the first set bit searching start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While owning, ptr_q is always owner+1, so one search serves both states.
  always_comb begin
    {pick_found, pick_idx} = rr_pick(req, ptr_q);
  end

  assign release_own = ~req[sel];
  assign preempt_own = (hold_cnt == HOLD_MAX) && ((req & ~gnt) != 4'b0000);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    gnt_d   = gnt;
    valid_d = gnt_valid;
    hold_d  = hold_cnt;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          sel_d   = pick_idx;
          gnt_d   = 4'b0001 << pick_idx;
          valid_d = 1'b1;
          hold_d  = HOLD_ONE;
          ptr_d   = pick_idx + 2'd1;
        end
      end
      OWN: begin
        if (release_own || preempt_own) begin
          if (pick_found) begin
            sel_d   = pick_idx;
            gnt_d   = 4'b0001 << pick_idx;
            valid_d = 1'b1;
            hold_d  = HOLD_ONE;
            ptr_d   = pick_idx + 2'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_cnt < HOLD_MAX) begin
          hold_d = hold_cnt + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      sel       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel       <= sel_d;
      gnt       <= gnt_d;
      gnt_valid <= valid_d;
      hold_cnt  <= hold_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Bench for mux_sel_rr_arbiter: directed scenarios plus random requests checked
// against an owner/pointer model of the arbitration rules.
module tb_mux_sel_rr_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [1:0]       sel;
  logic [3:0]       gnt;
  logic             gnt_valid;
  logic [CNT_W-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  int m_owner;   // -1 when no owner
  int m_hold;
  int m_ptr;
  int m_sel;

  mux_sel_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .gnt(gnt),
    .gnt_valid(gnt_valid), .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int search(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_ptr = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    int k;
    bit others;
    if (m_owner < 0) begin
      w = search(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_hold = 1; m_ptr = (w + 1) % 4;
      end
    end else begin
      k = m_owner;
      others = (r & ~(4'b0001 << k)) != 4'b0000;
      if (r[k] && !(m_hold == MAX_HOLD && others)) begin
        if (m_hold < MAX_HOLD) m_hold++;
      end else begin
        w = search(r, (k + 1) % 4);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_hold = 1; m_ptr = (w + 1) % 4;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // drive req at the falling edge, let the DUT and model take the rising edge
  task automatic cycle(input logic [3:0] v);
    @(negedge clk);
    req = v;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #2;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || sel !== 2'd0 || hold_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b valid=%b sel=%0d hold=%0d, required 0000/0/0/0",
               gnt, gnt_valid, sel, hold_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    int exp_own[5] = '{0, 1, 2, 3, 0};
    logic [3:0] r;
    do_reset();
    r = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle(r);
      checks++;
      if (sel !== 2'(exp_own[i]) || gnt !== 4'(1 << exp_own[i]) || gnt_valid !== 1'b1 ||
          hold_cnt !== 3'd1) begin
        errors++;
        $display("FAIL rotation[%0d]: sel=%0d gnt=%b valid=%b hold=%0d, required sel=%0d gnt=%b valid=1 hold=1",
                 i, sel, gnt, gnt_valid, hold_cnt, exp_own[i], 4'(1 << exp_own[i]));
      end
      r = 4'b1111 & ~(4'b0001 << exp_own[i]);
    end
  endtask

  task automatic test_preempt();
    logic [3:0] seq[5] = '{4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0101};
    logic [3:0] eg[5]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    int         eh[5]  = '{1, 2, 3, 4, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(seq[i]);
      checks++;
      if (gnt !== eg[i] || hold_cnt !== 3'(eh[i]) || sel !== 2'(m_sel)) begin
        errors++;
        $display("FAIL preempt[%0d]: gnt=%b hold=%0d sel=%0d, required gnt=%b hold=%0d sel=%0d",
                 i, gnt, hold_cnt, sel, eg[i], eh[i], m_sel);
      end
    end
  endtask

  task automatic test_sole();
    int eh;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(4'b1000);
      eh = (i + 1 < MAX_HOLD) ? i + 1 : MAX_HOLD;
      checks++;
      if (gnt !== 4'b1000 || sel !== 2'd3 || gnt_valid !== 1'b1 || hold_cnt !== 3'(eh)) begin
        errors++;
        $display("FAIL sole[%0d]: gnt=%b sel=%0d valid=%b hold=%0d, required 1000/3/1/%0d",
                 i, gnt, sel, gnt_valid, hold_cnt, eh);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    // an owner (channel 3) is active from test_sole
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_async: gnt=%b valid=%b sel=%0d, required 0000/0/0", gnt, gnt_valid, sel);
    end
    @(negedge clk);
    req   = 4'b1010;
    rst_n = 1'b1;
    @(posedge clk);
    model_step(4'b1010);
    #1;
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1 || gnt_valid !== 1'b1 || hold_cnt !== 3'd1) begin
      errors++;
      $display("FAIL reset_release: gnt=%b sel=%0d valid=%b hold=%0d, required 0010/1/1/1",
               gnt, sel, gnt_valid, hold_cnt);
    end
  endtask

  task automatic test_release_idle();
    do_reset();
    cycle(4'b0010);
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      errors++;
      $display("FAIL idle_grant1: gnt=%b sel=%0d, required 0010/1", gnt, sel);
    end
    cycle(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || sel !== 2'd1) begin
      errors++;
      $display("FAIL idle_release: gnt=%b valid=%b sel=%0d, required 0000/0/1", gnt, gnt_valid, sel);
    end
    cycle(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || sel !== 2'd1) begin
      errors++;
      $display("FAIL idle_stay: gnt=%b valid=%b sel=%0d, required 0000/0/1", gnt, gnt_valid, sel);
    end
    cycle(4'b0011);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || hold_cnt !== 3'd1) begin
      errors++;
      $display("FAIL idle_wrap: gnt=%b sel=%0d hold=%0d, required 0001/0/1", gnt, sel, hold_cnt);
    end
  endtask

  task automatic test_mux();
    logic [3:0] mux_in = 4'b1101;  // in0=1 in1=0 in2=1 in3=1
    logic       exp_out[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       mux_out;
    logic [3:0] r;
    do_reset();
    r = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cycle(r);
      mux_out = mux_in[sel];
      checks++;
      if (mux_out !== exp_out[i] || sel !== 2'(i)) begin
        errors++;
        $display("FAIL mux[%0d]: out=%b sel=%0d, required out=%b sel=%0d",
                 i, mux_out, sel, exp_out[i], i);
      end
      r = 4'b1111 & ~(4'b0001 << i);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int bad;
    do_reset();
    r   = 4'b0000;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
      cycle(r);
      checks++;
      if (gnt !== exp_gnt() || gnt_valid !== (m_owner >= 0) || sel !== 2'(m_sel) ||
          (m_owner >= 0 && hold_cnt !== 3'(m_hold))) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] req=%b: gnt=%b valid=%b sel=%0d hold=%0d, required gnt=%b valid=%0d sel=%0d hold=%0d",
                   i, r, gnt, gnt_valid, sel, hold_cnt, exp_gnt(), (m_owner >= 0), m_sel, m_hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_preempt();
    test_sole();
    test_reset_mid_grant();
    test_release_idle();
    test_mux();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
